// File: rtl/trapez_peak_sequencer.sv
// Per-pulse readout controller for the trapezoidal shaper.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | first cycle after reset release: check config, load timer
// S_CFG_ERR | bad configuration seen; one cycle before the error result
// S_RISE    | waiting out shaper pipeline latency + rise + leading gap
// S_FLAT    | accumulating 2^n flat-top samples
// S_RESULT  | energy word presented, waiting for res_ready
// S_DONE    | result delivered (or shaper disabled); idle until reset
//
// k, l and gap are only consumed on the first cycle after release (config
// check and timer load), so only the averaging exponent is kept in a flop.
module trapez_peak_sequencer #(
   parameter int DATA_W       = 16,
   parameter int CONST_W      = 12,
   parameter int PIPE_LAT     = 9,
   parameter int MAX_AVG_LOG2 = 6,
   parameter int ACC_W        = DATA_W + MAX_AVG_LOG2
) (
   input  logic               clk,
   input  logic               reset_mult,
   input  logic               trapez_ena,
   input  logic [CONST_W-1:0] k_trapez,
   input  logic [CONST_W-1:0] l_trapez,
   input  logic [CONST_W-1:0] gap_trapez,
   input  logic [2:0]         avg_log2,
   input  logic [DATA_W-1:0]  shaper_data,
   input  logic               pile_up,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_energy,
   output logic [1:0]         res_flags,
   output logic               busy
);

   localparam int CNT_W = CONST_W + 2;
   localparam int CHK_W = CONST_W + 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG_ERR,
      S_RISE,
      S_FLAT,
      S_RESULT,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [2:0]               n_q, n_d;
   logic                     res_valid_q, res_valid_d;
   logic [DATA_W-1:0]        res_energy_q, res_energy_d;
   logic [1:0]               res_flags_q, res_flags_d;
   logic                     busy_q, busy_d;

   logic signed [CHK_W-1:0]  span;
   logic signed [CHK_W-1:0]  n_avg;
   logic                     cfg_err;
   logic [CNT_W-1:0]         cnt_dec;
   logic signed [ACC_W-1:0]  sample_ext;
   logic signed [ACC_W-1:0]  acc_sum;

   // Configuration check at full precision: flat window after both guards must hold 2^n samples.
   always_comb begin
      span    = $signed({3'b000, l_trapez}) - $signed({3'b000, k_trapez})
              - $signed({2'b00, gap_trapez, 1'b0});
      n_avg   = $signed(CHK_W'(1) << avg_log2);
      cfg_err = (l_trapez <= k_trapez) || (avg_log2 > 3'(MAX_AVG_LOG2)) || (span < n_avg);
   end

   // Datapath helpers: timer decrement and sign-extended running sum.
   always_comb begin
      cnt_dec    = cnt_q - CNT_W'(1);
      sample_ext = $signed({{(ACC_W-DATA_W){shaper_data[DATA_W-1]}}, shaper_data});
      acc_sum    = acc_q + sample_ext;
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      n_d          = n_q;
      res_valid_d  = res_valid_q;
      res_energy_d = res_energy_q;
      res_flags_d  = res_flags_q;
      case (state_q)
         S_IDLE: begin
            n_d = avg_log2;
            if (!trapez_ena) begin
               state_d = S_DONE;
            end else if (cfg_err) begin
               state_d = S_CFG_ERR;
            end else begin
               cnt_d   = CNT_W'(PIPE_LAT) + CNT_W'(k_trapez) + CNT_W'(gap_trapez) - CNT_W'(1);
               state_d = S_RISE;
            end
         end
         S_CFG_ERR: begin
            state_d      = S_RESULT;
            res_valid_d  = 1'b1;
            res_energy_d = '0;
            res_flags_d  = 2'b10;
         end
         S_RISE: begin
            if (pile_up) begin
               state_d      = S_RESULT;
               res_valid_d  = 1'b1;
               res_energy_d = '0;
               res_flags_d  = 2'b01;
            end else begin
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
                  acc_d   = '0;
                  cnt_d   = (CNT_W'(1) << n_q) - CNT_W'(1);
                  state_d = S_FLAT;
               end
            end
         end
         S_FLAT: begin
            if (pile_up) begin
               state_d      = S_RESULT;
               res_valid_d  = 1'b1;
               res_energy_d = '0;
               res_flags_d  = 2'b01;
            end else begin
               acc_d = acc_sum;
               cnt_d = cnt_dec;
               if (cnt_q == '0) begin
                  state_d      = S_RESULT;
                  res_valid_d  = 1'b1;
                  res_energy_d = DATA_W'(acc_sum >>> n_q);
                  res_flags_d  = 2'b00;
               end
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               state_d     = S_DONE;
               res_valid_d = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_DONE;
         end
      endcase
      busy_d = (state_d == S_RISE) || (state_d == S_FLAT);
   end

   // State, counters and outputs; reset_mult low clears the whole pulse context.
   always_ff @(posedge clk or negedge reset_mult) begin
      if (!reset_mult) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         n_q          <= '0;
         res_valid_q  <= 1'b0;
         res_energy_q <= '0;
         res_flags_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         n_q          <= n_d;
         res_valid_q  <= res_valid_d;
         res_energy_q <= res_energy_d;
         res_flags_q  <= res_flags_d;
         busy_q       <= busy_d;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_energy = res_energy_q;
   assign res_flags  = res_flags_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_trapez_peak_sequencer.sv
// Directed bench for trapez_peak_sequencer. Cycle c is the interval after
// the c-th rising clk edge following reset_mult release.
module tb_trapez_peak_sequencer;

   logic               clk = 1'b0;
   logic               reset_mult = 1'b0;
   logic               trapez_ena = 1'b0;
   logic [11:0]        k_trapez = '0;
   logic [11:0]        l_trapez = '0;
   logic [11:0]        gap_trapez = '0;
   logic [2:0]         avg_log2 = '0;
   logic signed [15:0] shaper_data = '0;
   logic               pile_up = 1'b0;
   logic               res_ready = 1'b1;
   logic               res_valid;
   logic [15:0]        res_energy;
   logic [1:0]         res_flags;
   logic               busy;

   int checks = 0;
   int errors = 0;

   int          v_first, v_cnt, v_rises, b_first, b_last, b_cnt;
   logic [15:0] e_obs;
   logic [1:0]  f_obs;
   bit          hold_bad;
   logic        prev_valid;

   trapez_peak_sequencer dut (
      .clk        (clk),
      .reset_mult (reset_mult),
      .trapez_ena (trapez_ena),
      .k_trapez   (k_trapez),
      .l_trapez   (l_trapez),
      .gap_trapez (gap_trapez),
      .avg_log2   (avg_log2),
      .shaper_data(shaper_data),
      .pile_up    (pile_up),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_energy (res_energy),
      .res_flags  (res_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic start_window(input int k, input int l, input int gap, input int n, input bit ena);
      reset_mult  = 1'b0;
      pile_up     = 1'b0;
      res_ready   = 1'b1;
      shaper_data = 16'sd1000;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      k_trapez   = 12'(k);
      l_trapez   = 12'(l);
      gap_trapez = 12'(gap);
      avg_log2   = 3'(n);
      trapez_ena = ena;
      reset_mult = 1'b1;
   endtask

   // Runs ncyc cycles of a window and records what the DUT did.
   task automatic run_window(input int ncyc, input int pile_cyc, input bit alt, input int ready_lo);
      v_first = 0; v_cnt = 0; v_rises = 0;
      b_first = 0; b_last = 0; b_cnt = 0;
      e_obs = '0; f_obs = '0; hold_bad = 1'b0; prev_valid = 1'b0;
      res_ready = (ready_lo == 0);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         if (busy) begin
            if (b_first == 0) b_first = c;
            b_last = c;
            b_cnt++;
         end
         if (res_valid) begin
            v_cnt++;
            if (!prev_valid) begin
               v_rises++;
               if (v_first == 0) begin
                  v_first = c;
                  e_obs   = res_energy;
                  f_obs   = res_flags;
               end
            end else if (res_energy !== e_obs || res_flags !== f_obs) begin
               hold_bad = 1'b1;
            end
         end
         prev_valid  = res_valid;
         pile_up     = (c == pile_cyc);
         shaper_data = alt ? ((c % 2 == 1) ? -16'sd7 : -16'sd8) : 16'sd1000;
         if (ready_lo > 0 && v_first != 0 && c >= v_first + ready_lo) res_ready = 1'b1;
      end
      pile_up = 1'b0;
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset_mult = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
      checks++; if (res_energy !== 16'h0000) begin errors++; $display("FAIL rst_energy: got %h expected 0000", res_energy); end
      checks++; if (res_flags !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", res_flags); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
   endtask

   task automatic test_valid_window();
      start_window(20, 60, 4, 3, 1'b1);
      run_window(60, 0, 1'b0, 0);
      check_int("t1_valid_cycle", v_first, 41);
      check_int("t1_valid_cycles", v_cnt, 1);
      checks++; if (e_obs !== 16'd1000) begin errors++; $display("FAIL t1_energy: got %0d expected 1000", $signed(e_obs)); end
      checks++; if (f_obs !== 2'b00) begin errors++; $display("FAIL t1_flags: got %b expected 00", f_obs); end
      check_int("t1_busy_first", b_first, 1);
      check_int("t1_busy_last", b_last, 40);
      check_int("t1_busy_cnt", b_cnt, 40);
   endtask

   task automatic test_negative_avg();
      start_window(20, 60, 4, 3, 1'b1);
      run_window(50, 0, 1'b1, 0);
      check_int("t2_valid_cycle", v_first, 41);
      checks++; if (e_obs !== 16'hFFF8) begin errors++; $display("FAIL t2_energy: got %0d expected -8", $signed(e_obs)); end
   endtask

   task automatic test_config_error();
      start_window(20, 20, 4, 3, 1'b1);
      run_window(10, 0, 1'b0, 0);
      check_int("t3_valid_cycle", v_first, 2);
      checks++; if (e_obs !== 16'h0000) begin errors++; $display("FAIL t3_energy: got %h expected 0000", e_obs); end
      checks++; if (f_obs !== 2'b10) begin errors++; $display("FAIL t3_flags: got %b expected 10", f_obs); end
      check_int("t3_busy_cnt", b_cnt, 0);
      // 2^4 exceeds the 8-sample window left by gap=16
      start_window(20, 60, 16, 4, 1'b1);
      run_window(10, 0, 1'b0, 0);
      check_int("t3_span_err_cycle", v_first, 2);
      checks++; if (f_obs !== 2'b10) begin errors++; $display("FAIL t3_span_err_flags: got %b expected 10", f_obs); end
      // exactly 2^3 fits the 8-sample window
      start_window(20, 60, 16, 3, 1'b1);
      run_window(60, 0, 1'b0, 0);
      check_int("t3_span_ok_cycle", v_first, 53);
      checks++; if (f_obs !== 2'b00 || e_obs !== 16'd1000) begin errors++; $display("FAIL t3_span_ok: got flags %b energy %0d expected 00 1000", f_obs, $signed(e_obs)); end
      start_window(20, 1000, 4, 7, 1'b1);
      run_window(10, 0, 1'b0, 0);
      checks++; if (f_obs !== 2'b10) begin errors++; $display("FAIL t3_n_too_big: got %b expected 10", f_obs); end
   endtask

   task automatic test_backpressure();
      start_window(20, 60, 4, 3, 1'b1);
      run_window(70, 0, 1'b0, 5);
      check_int("t4_valid_cycle", v_first, 41);
      check_int("t4_valid_cycles", v_cnt, 6);
      check_int("t4_valid_rises", v_rises, 1);
      check_int("t4_hold_stable", int'(hold_bad), 0);
      checks++; if (e_obs !== 16'd1000) begin errors++; $display("FAIL t4_energy: got %0d expected 1000", $signed(e_obs)); end
   endtask

   task automatic test_pile_up();
      start_window(20, 60, 4, 3, 1'b1);
      run_window(50, 35, 1'b0, 0);
      check_int("t5_valid_cycle", v_first, 36);
      checks++; if (e_obs !== 16'h0000 || f_obs !== 2'b01) begin errors++; $display("FAIL t5_abort: got energy %h flags %b expected 0000 01", e_obs, f_obs); end
      check_int("t5_busy_last", b_last, 35);
      start_window(20, 60, 4, 3, 1'b1);
      run_window(50, 40, 1'b0, 0);
      check_int("t5_last_valid_cycle", v_first, 41);
      checks++; if (e_obs !== 16'h0000 || f_obs !== 2'b01) begin errors++; $display("FAIL t5_last_abort: got energy %h flags %b expected 0000 01", e_obs, f_obs); end
   endtask

   task automatic test_reset_and_disable();
      start_window(20, 60, 4, 3, 1'b1);
      run_window(45, 0, 1'b0, 1000);
      check_int("t6_pending_valid", int'(res_valid), 1);
      #3;
      reset_mult = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL t6_async_valid: got %b expected 0", res_valid); end
      checks++; if (res_energy !== 16'h0000 || res_flags !== 2'b00) begin errors++; $display("FAIL t6_async_data: got %h %b expected 0000 00", res_energy, res_flags); end
      start_window(20, 60, 4, 3, 1'b1);
      run_window(50, 0, 1'b0, 0);
      check_int("t6_next_valid_cycle", v_first, 41);
      checks++; if (e_obs !== 16'd1000) begin errors++; $display("FAIL t6_next_energy: got %0d expected 1000", $signed(e_obs)); end
      start_window(20, 60, 4, 3, 1'b0);
      run_window(60, 0, 1'b0, 0);
      check_int("t6_disabled_rises", v_rises, 0);
      check_int("t6_disabled_busy", b_cnt, 0);
   endtask

   initial begin
      test_reset();
      test_valid_window();
      test_negative_avg();
      test_config_error();
      test_backpressure();
      test_pile_up();
      test_reset_and_disable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trapez_peak_sequencer.md
Name: trapez_peak_sequencer

Overview:
- Per-pulse controller for the trapezoidal shaper readout.
- Lives in the same reset_mult domain as the shaper, so each pulse window starts it from a clean state.
- Latches the shaper timing constants and waits out the pipeline latency plus the rise time. It then averages a power-of-two number of flat-top samples and hands one signed energy word downstream on a valid/ready handshake.
- Also detects bad configuration and pile-up aborts.

Parameters:
DATA_W, 16, width of shaper output_data samples (signed)
CONST_W, 12, width of k/l/gap constants
PIPE_LAT, 9, fixed shaper pipeline latency in clk cycles from window open to first valid sample
MAX_AVG_LOG2, 6, largest allowed averaging exponent
ACC_W, DATA_W+MAX_AVG_LOG2, accumulator width

Ports:
clk  in  1  clock
reset_mult  in  1  asynchronous, active-low reset; low between pulses, high for one pulse window
trapez_ena  in  1  shaper enabled; sampled once on the first cycle after reset release
k_trapez  in  CONST_W  rise length k (cycles)
l_trapez  in  CONST_W  k+flat length l (cycles)
gap_trapez  in  CONST_W  guard cycles skipped at each flat-top edge
avg_log2  in  3  averaging exponent n; sample count N = 2^n
shaper_data  in  DATA_W  signed shaper output_data
pile_up  in  1  second-pulse detect from the trigger logic
res_valid  out  1  energy result valid
res_ready  in  1  downstream accepts result
res_energy  out  DATA_W  signed averaged flat-top value
res_flags  out  2  bit0 pile-up abort, bit1 config error
busy  out  1  high in states RISE and FLAT

Behaviour:
- Reset (reset_mult low) forces:
  - state=IDLE, all counters and the accumulator to 0
  - res_valid=0, res_energy=0, res_flags=0, busy=0
  - latched constants to 0
- IDLE, first clk after reset release:
  - Latch k, l, gap and n.
  - If trapez_ena=0: go to DONE; no result is produced.
  - Config error if l<=k, or n>MAX_AVG_LOG2, or 2^n > l-k-2*gap (evaluated at full precision, no wrap). On error: go to RESULT with energy 0 and flags=2'b10.
  - Otherwise: load cnt = PIPE_LAT + k + gap - 1 and go to RISE.
- RISE:
  - Decrement cnt each cycle.
  - At cnt==0: clear the accumulator, load cnt = 2^n - 1 and go to FLAT.
  - The first FLAT cycle accumulates the sample at absolute cycle PIPE_LAT+k+gap after release.
- FLAT:
  - Each cycle: acc += sign-extended shaper_data; decrement cnt.
  - After the cycle with cnt==0, go to RESULT with energy = acc >>> n (arithmetic shift, truncated to DATA_W) and flags=0.
- pile_up high in RISE or FLAT:
  - Abort immediately: go to RESULT with energy 0 and flags=2'b01. Partial accumulation is discarded.
  - pile_up is ignored in IDLE, RESULT and DONE.
  - If pile_up coincides with the last FLAT cycle, the abort wins.
- RESULT:
  - res_valid=1; res_energy and res_flags are held stable while res_valid=1 && res_ready=0.
  - Handshake completes on the clk edge where res_valid && res_ready; next state is DONE with res_valid=0.
  - res_valid never drops without a handshake, except by reset.
- DONE:
  - Idle until reset_mult falls; exactly one result per pulse window.
- Latency:
  - Valid window: res_valid rises on the clk edge after the last FLAT sample, i.e. cycle PIPE_LAT+k+gap+2^n after release.
  - Config error: res_valid rises on the 2nd clk after release.
  - No combinational path from res_ready to res_valid.
- Reset mid-operation (any state, including RESULT with an unaccepted result): everything clears asynchronously and the pending result is lost. Downstream must treat reset_mult low as flush.
- Arithmetic:
  - ACC_W is sized so 2^MAX_AVG_LOG2 full-scale samples never overflow.
  - Counters are CONST_W+2 bits so PIPE_LAT+k+gap cannot wrap.

Test Plan:
1. Valid window:
   - Stimulus: k=20, l=60, gap=4, n=3, trapez_ena=1, shaper_data held 1000 from release, res_ready=1.
   - Required: res_valid one cycle at release+41, res_energy=1000, flags=0; busy high for cycles 1..40.
2. Negative averaging:
   - Stimulus: as test 1 but shaper_data alternates -7/-8 over the 8 flat samples.
   - Required: energy = -60>>>3 = -8 (arithmetic floor).
3. Config error:
   - Stimulus: l=20, k=20.
   - Required: res_valid at cycle 2, energy=0, flags=2'b10, busy never high.
4. Backpressure:
   - Stimulus: res_ready low for 5 cycles after res_valid rises.
   - Required: res_valid, res_energy and res_flags stable for 5 cycles; clears the cycle after res_ready=1; no second result afterwards.
5. Pile-up abort:
   - Stimulus: pile_up pulse at cycle 35 (FLAT) of test 1.
   - Required: next cycle res_valid=1, energy=0, flags=2'b01.
   - Stimulus: pile_up on the last FLAT cycle.
   - Required: flags=2'b01.
6. Reset and disable:
   - Stimulus: reset_mult dropped while res_valid=1 and res_ready=0.
   - Required: res_valid=0 immediately (asynchronous); next window behaves as test 1.
   - Stimulus: trapez_ena=0 at release.
   - Required: no res_valid in the window.
